// File: rtl/uart_phy_line.sv
// UART physical layer for the ISP debug port.
// 8N1 receiver with 4x oversampling, plus an 8-character line transmitter.
// Optional build macro SKIP_NUL_EN: when defined, 8'h00 characters in a line
// are skipped and take no time on the wire.
module uart_phy_line #(
  parameter int unsigned UART_RX_CLK_DIV = 108,
  parameter int unsigned UART_TX_CLK_DIV = 434
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        i_rx,
  output logic        o_ready,
  output logic [7:0]  o_data,
  output logic        o_tx,
  input  logic        i_start,
  input  logic [63:0] i_data,
  output logic        o_fin
);

  localparam int unsigned RxCntW = (UART_RX_CLK_DIV > 1) ? $clog2(UART_RX_CLK_DIV) : 1;
  localparam int unsigned TxCntW = (UART_TX_CLK_DIV > 1) ? $clog2(UART_TX_CLK_DIV) : 1;
  localparam logic [RxCntW-1:0] RxCntMax = RxCntW'(UART_RX_CLK_DIV - 1);
  localparam logic [TxCntW-1:0] TxCntMax = TxCntW'(UART_TX_CLK_DIV - 1);

  // ---------------------------------------------------------------------------
  // Receiver
  // ---------------------------------------------------------------------------
  typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxStop, RxWait} rx_state_e;

  logic              rx_meta;
  logic              rx_sync;
  logic [RxCntW-1:0] rx_cnt;
  logic              rx_tick;
  rx_state_e         rx_state;
  logic [1:0]        rx_phase;
  logic [1:0]        rx_ph_now;
  logic [2:0]        rx_bit;
  logic [7:0]        rx_shift;

  assign rx_tick   = (rx_cnt == RxCntMax);
  // rx_phase holds the phase of the previous tick; this is the phase of the current one.
  assign rx_ph_now = rx_phase + 2'd1;

  // Two-flop synchronizer for the asynchronous rx pin, idling high.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= i_rx;
      rx_sync <= rx_meta;
    end
  end

  // Free-running divider producing the 4x-baud sample tick.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_cnt <= '0;
    end else if (rx_tick) begin
      rx_cnt <= '0;
    end else begin
      rx_cnt <= rx_cnt + 1'b1;
    end
  end

  // Receive FSM: each bit spans four ticks and is sampled at phase 2.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_state <= RxIdle;
      rx_phase <= 2'd0;
      rx_bit   <= 3'd0;
      rx_shift <= 8'h00;
      o_ready  <= 1'b0;
      o_data   <= 8'h00;
    end else begin
      o_ready <= 1'b0;
      unique case (rx_state)
        RxIdle: begin
          if (rx_tick && !rx_sync) begin
            rx_state <= RxStart;
            rx_phase <= 2'd0;
          end
        end
        RxStart: begin
          if (rx_tick) begin
            rx_phase <= rx_ph_now;
            if (rx_ph_now == 2'd2 && rx_sync) begin
              rx_state <= RxIdle;  // glitch, not a real start bit
            end else if (rx_ph_now == 2'd3) begin
              rx_state <= RxData;
              rx_bit   <= 3'd0;
            end
          end
        end
        RxData: begin
          if (rx_tick) begin
            rx_phase <= rx_ph_now;
            if (rx_ph_now == 2'd2) begin
              rx_shift <= {rx_sync, rx_shift[7:1]};
            end else if (rx_ph_now == 2'd3) begin
              if (rx_bit == 3'd7) begin
                rx_state <= RxStop;
              end else begin
                rx_bit <= rx_bit + 3'd1;
              end
            end
          end
        end
        RxStop: begin
          if (rx_tick) begin
            rx_phase <= rx_ph_now;
            if (rx_ph_now == 2'd2) begin
              if (rx_sync) begin
                o_data   <= rx_shift;
                o_ready  <= 1'b1;
                rx_state <= RxIdle;
              end else begin
                rx_state <= RxWait;  // framing error: drop the byte
              end
            end
          end
        end
        RxWait: begin
          if (rx_sync) begin
            rx_state <= RxIdle;
          end
        end
        default: rx_state <= RxIdle;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Transmitter
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {TxIdle, TxSend, TxFin} tx_state_e;

  typedef struct packed {
    logic [63:0] line;
    logic [3:0]  left;
  } tx_line_t;

  tx_state_e         tx_state;
  logic [TxCntW-1:0] tx_cnt;
  logic [3:0]        tx_bit;
  logic [63:0]       tx_line;
  logic [3:0]        tx_left;
  tx_line_t          tx_first;
  tx_line_t          tx_next;
  tx_line_t          tx_first_raw;
  tx_line_t          tx_next_raw;

  // Drop leading NUL characters so the next character to send sits in the top byte.
  function automatic tx_line_t skip_nul(input tx_line_t in);
    tx_line_t res;
    res = in;
`ifdef SKIP_NUL_EN
    for (int i = 0; i < 8; i++) begin
      if (res.left != 4'd0 && res.line[63:56] == 8'h00) begin
        res.line = res.line << 8;
        res.left = res.left - 4'd1;
      end
    end
`endif
    return res;
  endfunction

  // Line level for bit index b of a frame: start, 8 data bits LSB first, stop.
  function automatic logic tx_bit_val(input logic [3:0] b, input logic [7:0] c);
    logic [3:0] idx;
    idx = b - 4'd1;
    if (b == 4'd0) begin
      return 1'b0;
    end else if (b >= 4'd9) begin
      return 1'b1;
    end else begin
      return c[idx[2:0]];
    end
  endfunction

  // Character selection for a new line and for the character after the current one.
  always_comb begin
    tx_first_raw.line = i_data;
    tx_first_raw.left = 4'd8;
    tx_next_raw.line  = tx_line << 8;
    tx_next_raw.left  = tx_left - 4'd1;
    tx_first          = skip_nul(tx_first_raw);
    tx_next           = skip_nul(tx_next_raw);
  end

  // Transmit FSM with registered line and completion outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tx_state <= TxIdle;
      tx_cnt   <= '0;
      tx_bit   <= 4'd0;
      tx_line  <= 64'h0;
      tx_left  <= 4'd0;
      o_tx     <= 1'b1;
      o_fin    <= 1'b0;
    end else begin
      o_fin <= 1'b0;
      unique case (tx_state)
        TxIdle: begin
          if (i_start) begin
            tx_line <= tx_first.line;
            tx_left <= tx_first.left;
            tx_cnt  <= '0;
            tx_bit  <= 4'd0;
            if (tx_first.left == 4'd0) begin
              tx_state <= TxFin;  // nothing to send
              o_fin    <= 1'b1;
            end else begin
              tx_state <= TxSend;
              o_tx     <= 1'b0;
            end
          end
        end
        TxSend: begin
          if (tx_cnt == TxCntMax) begin
            tx_cnt <= '0;
            if (tx_bit == 4'd9) begin
              tx_line <= tx_next.line;
              tx_left <= tx_next.left;
              tx_bit  <= 4'd0;
              if (tx_next.left == 4'd0) begin
                tx_state <= TxFin;
                o_fin    <= 1'b1;
                o_tx     <= 1'b1;
              end else begin
                o_tx <= 1'b0;  // next start bit follows the stop bit directly
              end
            end else begin
              tx_bit <= tx_bit + 4'd1;
              o_tx   <= tx_bit_val(tx_bit + 4'd1, tx_line[63:56]);
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        TxFin: begin
          tx_state <= TxIdle;  // i_start during the o_fin cycle is ignored
        end
        default: tx_state <= TxIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_phy_line.sv
// Scoreboard bench for uart_phy_line: expected rx bytes, tx characters and
// o_fin cycles are queued by the stimulus and consumed by independent monitors.
module tb_uart_phy_line;

  localparam int RX_DIV = 4;
  localparam int TX_DIV = 16;
  localparam int BIT    = 16;

  logic        clk;
  logic        rstn;
  logic        rx_drv;
  logic        loop_en;
  logic        i_rx;
  logic        o_ready;
  logic [7:0]  o_data;
  logic        o_tx;
  logic        i_start;
  logic [63:0] i_data;
  logic        o_fin;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int rdy_cnt = 0;
  int fin_cnt = 0;
  int last_rdy_cyc = 0;

  logic [7:0] exp_rx[$];
  logic [7:0] exp_tx[$];
  int         exp_fin[$];

  assign i_rx = loop_en ? o_tx : rx_drv;

  uart_phy_line #(
    .UART_RX_CLK_DIV(RX_DIV),
    .UART_TX_CLK_DIV(TX_DIV)
  ) dut (
    .clk    (clk),
    .rstn   (rstn),
    .i_rx   (i_rx),
    .o_ready(o_ready),
    .o_data (o_data),
    .o_tx   (o_tx),
    .i_start(i_start),
    .i_data (i_data),
    .o_fin  (o_fin)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Receive monitor.
  always @(negedge clk) begin
    if (rstn && o_ready) begin
      rdy_cnt++;
      last_rdy_cyc = cyc;
      if (exp_rx.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL rx_unexpected: got o_ready with o_data 0x%0h, expected none", o_data);
      end else begin
        check("rx_byte", 64'(o_data), 64'(exp_rx.pop_front()));
      end
    end
  end

  // Completion monitor.
  always @(negedge clk) begin
    if (rstn && o_fin) begin
      fin_cnt++;
      if (exp_fin.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL fin_unexpected: got o_fin at cycle %0d, expected none", cyc);
      end else begin
        check("fin_cycle", 64'(cyc), 64'(exp_fin.pop_front()));
      end
    end
  end

  // Serial decoder on o_tx, sampling each bit at its middle.
  initial begin : tx_decoder
    logic [9:0] fr;
    bit         ab;
    forever begin
      @(negedge clk);
      if (rstn && o_tx === 1'b0) begin
        ab = 1'b0;
        fr = '0;
        for (int k = 0; k < 10; k++) begin
          repeat ((k == 0) ? BIT / 2 : BIT) @(negedge clk);
          if (!rstn) ab = 1'b1;
          fr[k] = o_tx;
        end
        if (!ab) begin
          check("tx_start_stop", 64'({fr[9], fr[0]}), 64'(2'b10));
          if (exp_tx.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL tx_unexpected: got char 0x%0h, expected none", fr[8:1]);
          end else begin
            check("tx_char", 64'(fr[8:1]), 64'(exp_tx.pop_front()));
          end
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rx_bit(input logic v);
    rx_drv = v;
    repeat (BIT) @(posedge clk);
    #1;
  endtask

  task automatic rx_frame(input logic [7:0] b, input logic stop);
    rx_bit(1'b0);
    for (int k = 0; k < 8; k++) rx_bit(b[k]);
    rx_bit(stop);
    rx_drv = 1'b1;
  endtask

  task automatic push_line(input logic [63:0] d);
    for (int k = 0; k < 8; k++) exp_tx.push_back(d[63 - 8 * k -: 8]);
  endtask

  task automatic tx_launch(input logic [63:0] d, output int c1);
    i_data  = d;
    i_start = 1'b1;
    @(posedge clk);
    #1;
    i_start = 1'b0;
    c1      = cyc;
  endtask

  initial begin : stim
    int c1;
    int e;
    int r0;
    int f0;
    int lat;
    logic [63:0] d;

    rstn    = 1'b0;
    rx_drv  = 1'b1;
    loop_en = 1'b0;
    i_start = 1'b0;
    i_data  = 64'h0;

    // Reset values.
    idle(5);
    check("rst_tx", 64'(o_tx), 64'(1'b1));
    check("rst_ready", 64'(o_ready), 64'(1'b0));
    check("rst_fin", 64'(o_fin), 64'(1'b0));
    check("rst_data", 64'(o_data), 64'(8'h00));
    rstn = 1'b1;
    idle(2000);
    check("idle_no_ready", 64'(rdy_cnt), 64'(0));
    check("idle_no_fin", 64'(fin_cnt), 64'(0));
    check("idle_tx_high", 64'(o_tx), 64'(1'b1));

    // Received byte 'R' and its latency from the start edge.
    r0 = rdy_cnt;
    exp_rx.push_back(8'h52);
    e = cyc;
    rx_frame(8'h52, 1'b1);
    idle(40);
    lat = last_rdy_cyc - e;
    check("rx_one_pulse", 64'(rdy_cnt - r0), 64'(1));
    check("rx_latency_window", 64'(lat >= 140 && lat <= 175), 64'(1));

    // Four-cycle low glitch must not start a frame.
    r0 = rdy_cnt;
    rx_drv = 1'b0;
    idle(4);
    rx_drv = 1'b1;
    idle(200);
    check("rx_false_start", 64'(rdy_cnt - r0), 64'(0));

    // Framing error drops the byte; the next byte still arrives.
    r0 = rdy_cnt;
    rx_frame(8'hA5, 1'b0);
    idle(32);
    check("rx_framing_drop", 64'(rdy_cnt - r0), 64'(0));
    exp_rx.push_back(8'h3C);
    rx_frame(8'h3C, 1'b1);
    idle(40);
    check("rx_after_framing", 64'(rdy_cnt - r0), 64'(1));
    check("rx_queue_empty", 64'(exp_rx.size()), 64'(0));

    // Line "wr done " with a mid-line restart and a start on the o_fin cycle.
    f0 = fin_cnt;
    d  = 64'h7772_2064_6F6E_6520;
    push_line(d);
    tx_launch(d, c1);
    exp_fin.push_back(c1 + 80 * TX_DIV);
    check("tx_start_bit", 64'(o_tx), 64'(1'b0));
    idle(600);
    i_data  = 64'hFFFF_FFFF_FFFF_FFFF;
    i_start = 1'b1;
    idle(1);
    i_start = 1'b0;
    idle(80 * TX_DIV - 601);
    check("fin_at_1280", 64'(o_fin), 64'(1'b1));
    i_data  = 64'h4141_4141_4141_4141;
    i_start = 1'b1;
    idle(1);
    i_start = 1'b0;
    check("fin_one_cycle", 64'(o_fin), 64'(1'b0));
    idle(200);
    check("tx_line_chars_done", 64'(exp_tx.size()), 64'(0));
    check("tx_fin_once", 64'(fin_cnt - f0), 64'(1));
    check("tx_idle_after_fin", 64'(o_tx), 64'(1'b1));

    // Loopback of "\r\ndebug ".
    loop_en = 1'b1;
    r0 = rdy_cnt;
    d  = 64'h0D0A_6465_6275_6720;
    push_line(d);
    for (int k = 0; k < 8; k++) exp_rx.push_back(d[63 - 8 * k -: 8]);
    tx_launch(d, c1);
    exp_fin.push_back(c1 + 80 * TX_DIV);
    idle(80 * TX_DIV + 100);
    check("loop_ready_count", 64'(rdy_cnt - r0), 64'(8));
    check("loop_rx_empty", 64'(exp_rx.size()), 64'(0));
    check("loop_tx_empty", 64'(exp_tx.size()), 64'(0));
    check("loop_fin_empty", 64'(exp_fin.size()), 64'(0));
    loop_en = 1'b0;
    idle(20);

    // NUL characters: skipped when the option is built in, sent otherwise.
    d = 64'h4100_0000_0000_0042;
`ifdef SKIP_NUL_EN
    exp_tx.push_back(8'h41);
    exp_tx.push_back(8'h42);
    tx_launch(d, c1);
    exp_fin.push_back(c1 + 20 * TX_DIV);
    idle(20 * TX_DIV + 100);
`else
    push_line(d);
    tx_launch(d, c1);
    exp_fin.push_back(c1 + 80 * TX_DIV);
    idle(80 * TX_DIV + 100);
`endif
    check("nul_tx_empty", 64'(exp_tx.size()), 64'(0));
    check("nul_fin_empty", 64'(exp_fin.size()), 64'(0));

    // Reset mid-line aborts it: line high at once and no o_fin.
    f0 = fin_cnt;
    tx_launch(64'h5555_5555_5555_5555, c1);
    idle(40);
    rstn = 1'b0;
    #1;
    check("midrst_tx_high", 64'(o_tx), 64'(1'b1));
    check("midrst_fin_low", 64'(o_fin), 64'(1'b0));
    idle(20);
    rstn = 1'b1;
    idle(1500);
    check("midrst_no_fin", 64'(fin_cnt - f0), 64'(0));
    check("midrst_tx_idle", 64'(o_tx), 64'(1'b1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
